spi_prot_trig: RTL and testbench
================================

# spi_prot_trig

Parametrised SPI protocol trigger for the logic analyzer's protocol trigger path. It watches three raw analyzer channels (SS_n, SCLK, MOSI), deserialises frames of programmable length up to MAX_LEN bits, and compares each frame against a masked match word. It asserts a sticky trigger on the Nth matching frame. Over the 8/16-bit SPI receiver it adds: arbitrary frame length, LSB/MSB-first order, back-to-back frames within one SS_n window, frame-error detection, and occurrence counting.

## Interface
- MAX_LEN, 32, maximum frame length in bits (≥2)
- LEN_W, $clog2(MAX_LEN+1), width of len and internal bit counter
- CNT_W, 8, width of occurrence target and match counter
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- en  in  1  block enable; low holds FSM in IDLE, clears counters, SPItrig, match_cnt
- edg  in  1  sampling edge of SCLK: 1 = rising, 0 = falling
- lsb_first  in  1  1 = first received bit is bit 0; 0 = first bit is bit len-1
- len  in  LEN_W  frame length in bits; 0 or >MAX_LEN treated as MAX_LEN
- mask  in  MAX_LEN  bit = 1 is don't-care
- match  in  MAX_LEN  compare value
- occur  in  CNT_W  trigger on this many matching frames; 0 treated as 1
- clr_trig  in  1  one-cycle pulse: clears SPItrig and match_cnt
- SS_n, SCLK, MOSI  in  1 each  raw asynchronous channel inputs
- SPItrig  out  1  sticky trigger
- frame_done  out  1  one-cycle pulse per completed frame
- frame_err  out  1  one-cycle pulse on a truncated frame
- rx_data  out  MAX_LEN  last completed frame, bits ≥ len forced 0
- match_cnt  out  CNT_W  matching frames since clear, saturating

## Operation
- Each raw input passes through a 2-flop synchroniser, then one more flop for edge detection. Reset values: SS_n=1, SCLK=1, MOSI=1.
- Sample event: the selected SCLK edge on the synchronised signals while synchronised SS_n=0. MOSI is taken from the same synchroniser stage as the SCLK edge.
- FSM IDLE: bit_cnt=0. On SS_n falling go to SHIFT.
- FSM SHIFT, on each sample event:
  - MSB-first: shreg <= {shreg[MAX_LEN-2:0], MOSI}.
  - LSB-first: shreg[bit_cnt] <= MOSI.
  - bit_cnt increments.
- Frame completes when bit_cnt reaches len:
  - frame_done pulses.
  - rx_data <= shreg with bits ≥ len zeroed.
  - bit_cnt <= 0; remain in SHIFT for the next frame.
  - shreg clears.
- Match condition: ((frame ^ match) & ~mask & lenmask) == 0, where lenmask has bits [len-1:0] set.
- On a match, match_cnt increments, saturating at 2^CNT_W-1. SPItrig sets when the new count ≥ occur (occur 0 → 1).
- SS_n rising in SHIFT:
  - If bit_cnt ≠ 0: frame_err pulses and the partial frame is discarded (rx_data, match_cnt unchanged).
  - Go to IDLE in either case.
- SPItrig stays set until clr_trig, en low, or rst.
- clr_trig in the same cycle as a matching completion: the clear is applied first and the match counts as 1. SPItrig is then set only if occur ≤ 1.
- Changes to len, mask, match, or lsb_first mid-frame are undefined; software changes them only with en=0.

## Timing
- Reset and en-low values: FSM IDLE, bit_cnt 0, shreg 0, rx_data 0, match_cnt 0, SPItrig 0, frame_done 0, frame_err 0.
- Latency: a raw SCLK edge sampled at clock edge k is seen as an edge at k+2. Capture and frame completion register at k+3, so frame_done, rx_data, match_cnt and SPItrig update at clock k+3.
- Same latency applies from raw SS_n rising to frame_err.
- Input constraints:
  - SCLK high and low phases ≥ 3 clk periods.
  - MOSI stable ≥ 3 clk before and 1 clk after the sampling edge.
  - SS_n falling ≥ 3 clk before the first sampling edge.
- A sample edge and SS_n rising in the same synchronised cycle: the sample is taken first, then the SS_n rule is applied to the updated bit_cnt.
- rst asserted mid-frame aborts immediately with no pulses.

## Test plan
- MAX_LEN=32, len=16, MSB-first, edg=1, mask=0, match=16'hA5C3, occur=1; send 16'hA5C3 → frame_done once, rx_data=32'h0000A5C3, match_cnt=1, SPItrig=1 at SCLK edge + 3 clk.
- len=8, lsb_first=1, match=8'h01, mask=0; send bits 1,0,0,0,0,0,0,0 → rx_data=8'h01, SPItrig=1. Send MSB-first pattern 8'h01 with lsb_first=1 → rx_data=8'h80, no trigger.
- len=12, occur=3, mask=12'h00F, match=12'hAB0; three frames 12'hAB1, 12'hAB7, 12'hABF in one SS_n window → match_cnt 1,2,3; SPItrig only after the third frame.
- len=10; raise SS_n after 6 bits → frame_err one pulse, no frame_done, rx_data and match_cnt unchanged. Next full 10-bit frame decodes correctly.
- Trigger set, then clr_trig coincident with a matching frame completion, occur=2 → SPItrig=0, match_cnt=1. With occur=1 → SPItrig=1.
- len=0 with MAX_LEN=32; send 32 bits 32'hDEADBEEF, edg=0 → treated as 32-bit frame, rx_data=32'hDEADBEEF. Assert rst mid-frame → all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/spi_prot_trig.sv
// SPI protocol trigger: synchronises raw SS_n/SCLK/MOSI analyzer channels,
// deserialises frames of programmable length, compares each completed frame
// against a masked match word and raises a sticky trigger on the Nth match.
module spi_prot_trig #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               edg,
    input  logic               lsb_first,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] mask,
    input  logic [MAX_LEN-1:0] match,
    input  logic [CNT_W-1:0]   occur,
    input  logic               clr_trig,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               SPItrig,
    output logic               frame_done,
    output logic               frame_err,
    output logic [MAX_LEN-1:0] rx_data,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [MAX_LEN-1:0] DATA_ZERO = {MAX_LEN{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // A length of zero or beyond the register width means "use the full width".
    function automatic logic [LEN_W-1:0] eff_len_f(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if ((l == LEN_ZERO) || (l > LEN_MAX)) begin
            r = LEN_MAX;
        end else begin
            r = l;
        end
        return r;
    endfunction

    // Bits [n-1:0] set, all others clear.
    function automatic logic [MAX_LEN-1:0] len_mask_f(input logic [LEN_W-1:0] n);
        logic [MAX_LEN-1:0] m;
        m = DATA_ZERO;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (LEN_W'(i) < n);
        end
        return m;
    endfunction

    // Synchroniser chains: [0],[1] are the 2-flop synchroniser, [2] the edge-detect stage.
    logic [2:0] ss_sync_r;
    logic [2:0] sclk_sync_r;
    logic [2:0] mosi_sync_r;

    // Registered events seen on the synchronised signals.
    logic samp_r;
    logic mosi_r;
    logic ss_fall_r;
    logic ss_rise_r;

    state_t             state_r;
    logic [LEN_W-1:0]   bit_cnt_r;
    logic [MAX_LEN-1:0] shreg_r;

    // Combinational decode
    logic               sclk_rise_s;
    logic               sclk_fall_s;
    logic               samp_s;
    logic               ss_fall_s;
    logic               ss_rise_s;
    logic [LEN_W-1:0]   eff_len_s;
    logic [MAX_LEN-1:0] len_mask_s;
    logic [LEN_W-1:0]   cnt_inc_s;
    logic [MAX_LEN-1:0] shreg_next_s;
    logic               done_s;
    logic [MAX_LEN-1:0] frame_s;
    logic               hit_s;
    logic [CNT_W-1:0]   base_cnt_s;
    logic [CNT_W-1:0]   sat_cnt_s;
    logic [CNT_W-1:0]   occ_eff_s;
    logic [LEN_W-1:0]   upd_cnt_s;

    // Shift raw channels through the synchroniser and edge-detect stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync_r   <= 3'b111;
            sclk_sync_r <= 3'b111;
            mosi_sync_r <= 3'b111;
        end else begin
            ss_sync_r   <= {ss_sync_r[1:0], SS_n};
            sclk_sync_r <= {sclk_sync_r[1:0], SCLK};
            mosi_sync_r <= {mosi_sync_r[1:0], MOSI};
        end
    end

    // Detect SCLK/SS_n edges between the synchroniser output and the edge-detect stage.
    always_comb begin
        sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
        sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
        ss_fall_s   = ~ss_sync_r[1] & ss_sync_r[2];
        ss_rise_s   = ss_sync_r[1] & ~ss_sync_r[2];
        // A sample coinciding with SS_n rising is still taken (slave was selected until now).
        if (edg) begin
            samp_s = sclk_rise_s & ~(ss_sync_r[1] & ss_sync_r[2]);
        end else begin
            samp_s = sclk_fall_s & ~(ss_sync_r[1] & ss_sync_r[2]);
        end
    end

    // Register events and the MOSI value from the same stage as the SCLK edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_r    <= 1'b0;
            mosi_r    <= 1'b1;
            ss_fall_r <= 1'b0;
            ss_rise_r <= 1'b0;
        end else begin
            samp_r    <= samp_s;
            mosi_r    <= mosi_sync_r[1];
            ss_fall_r <= ss_fall_s;
            ss_rise_r <= ss_rise_s;
        end
    end

    // Next shift-register value, frame completion, match and counter arithmetic.
    always_comb begin
        eff_len_s  = eff_len_f(len);
        len_mask_s = len_mask_f(eff_len_s);
        cnt_inc_s  = bit_cnt_r + LEN_ONE;
        if (lsb_first) begin
            shreg_next_s = shreg_r;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (bit_cnt_r == LEN_W'(i)) begin
                    shreg_next_s[i] = mosi_r;
                end else begin
                    shreg_next_s[i] = shreg_r[i];
                end
            end
        end else begin
            shreg_next_s = {shreg_r[MAX_LEN-2:0], mosi_r};
        end
        done_s  = (cnt_inc_s == eff_len_s);
        frame_s = shreg_next_s & len_mask_s;
        hit_s   = (((frame_s ^ match) & ~mask & len_mask_s) == DATA_ZERO);
        // A coincident clear is applied before the new match is counted.
        if (clr_trig) begin
            base_cnt_s = CNT_ZERO;
        end else begin
            base_cnt_s = match_cnt;
        end
        if (base_cnt_s == CNT_MAX) begin
            sat_cnt_s = base_cnt_s;
        end else begin
            sat_cnt_s = base_cnt_s + CNT_ONE;
        end
        if (occur == CNT_ZERO) begin
            occ_eff_s = CNT_ONE;
        end else begin
            occ_eff_s = occur;
        end
        // Bit count after this cycle's sample, used to judge a truncated frame on SS_n rising.
        if (samp_r) begin
            if (done_s) begin
                upd_cnt_s = LEN_ZERO;
            end else begin
                upd_cnt_s = cnt_inc_s;
            end
        end else begin
            upd_cnt_s = bit_cnt_r;
        end
    end

    // Frame FSM with registered frame outputs, match counter and sticky trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= LEN_ZERO;
            shreg_r    <= DATA_ZERO;
            rx_data    <= DATA_ZERO;
            match_cnt  <= CNT_ZERO;
            SPItrig    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else if (!en) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= LEN_ZERO;
            shreg_r    <= DATA_ZERO;
            rx_data    <= DATA_ZERO;
            match_cnt  <= CNT_ZERO;
            SPItrig    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (clr_trig) begin
                SPItrig   <= 1'b0;
                match_cnt <= CNT_ZERO;
            end
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= LEN_ZERO;
                    if (ss_fall_r) begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (samp_r) begin
                        if (done_s) begin
                            frame_done <= 1'b1;
                            rx_data    <= frame_s;
                            shreg_r    <= DATA_ZERO;
                            bit_cnt_r  <= LEN_ZERO;
                            if (hit_s) begin
                                match_cnt <= sat_cnt_s;
                                if (sat_cnt_s >= occ_eff_s) begin
                                    SPItrig <= 1'b1;
                                end
                            end
                        end else begin
                            shreg_r   <= shreg_next_s;
                            bit_cnt_r <= cnt_inc_s;
                        end
                    end
                    if (ss_rise_r) begin
                        if (upd_cnt_s != LEN_ZERO) begin
                            frame_err <= 1'b1;
                        end
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= LEN_ZERO;
                        shreg_r   <= DATA_ZERO;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= LEN_ZERO;
                    shreg_r   <= DATA_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prot_trig.sv
// Scoreboard bench for spi_prot_trig: expected frame results are queued as
// each frame is driven and compared when frame_done pulses.
module tb_spi_prot_trig;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               edg;
    logic               lsb_first;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] match;
    logic [CNT_W-1:0]   occur;
    logic               clr_trig;
    logic               SS_n;
    logic               SCLK;
    logic               MOSI;
    logic               SPItrig;
    logic               frame_done;
    logic               frame_err;
    logic [MAX_LEN-1:0] rx_data;
    logic [CNT_W-1:0]   match_cnt;

    spi_prot_trig #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .edg(edg), .lsb_first(lsb_first),
        .len(len), .mask(mask), .match(match), .occur(occur),
        .clr_trig(clr_trig), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .SPItrig(SPItrig), .frame_done(frame_done), .frame_err(frame_err),
        .rx_data(rx_data), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rx;
        logic [7:0]  cnt;
        logic        trig;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    logic [31:0] m_rx;
    int          m_cnt;
    bit          m_trig;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (frame_err === 1'b1) err_seen++;
        if (frame_done === 1'b1) begin
            check_val("done_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("rx_data", 64'(rx_data), 64'(e.rx));
                check_val("match_cnt", 64'(match_cnt), 64'(e.cnt));
                check_val("SPItrig", 64'(SPItrig), 64'(e.trig));
            end
        end
    end

    function automatic logic [31:0] lmask(input logic [5:0] l);
        int n;
        n = (l == 6'd0 || l > 6'd32) ? 32 : int'(l);
        return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic logic [31:0] rev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++) r[i] = v[n-1-i];
        return r;
    endfunction

    task automatic configure(input logic [5:0] l, input bit ed, input bit lf,
                             input logic [31:0] mk, input logic [31:0] mt, input logic [7:0] oc);
        @(negedge clk);
        en = 1'b0; len = l; edg = ed; lsb_first = lf; mask = mk; match = mt; occur = oc;
        SCLK = ~ed; MOSI = 1'b1; SS_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("en_low_trig", 64'(SPItrig), 64'd0);
        check_val("en_low_cnt", 64'(match_cnt), 64'd0);
        en = 1'b1; m_cnt = 0; m_trig = 1'b0; m_rx = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    // mode 0: plain bit; 1: check frame_done latency; 2: clr_trig coincident with completion.
    task automatic spi_bit(input bit b, input int mode);
        MOSI = b;
        repeat (4) @(negedge clk);
        SCLK = edg;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (mode == 1 && n == 3) check_val("lat_early", 64'(frame_done), 64'd0);
            if (mode == 1 && n == 4) check_val("lat_done", 64'(frame_done), 64'd1);
            if (mode == 2 && n == 3) clr_trig = 1'b1;
            if (mode == 2 && n == 4) clr_trig = 1'b0;
        end
        SCLK = ~edg;
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        SS_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, input bit wire_msb,
                              input bit do_clr, input bit lat);
        logic [31:0] lm;
        logic [31:0] rx_exp;
        bit          hit;
        int          occ;
        exp_t        e;
        lm = lmask(len);
        rx_exp = (lsb_first != wire_msb) ? (v & lm) : rev(v, n);
        hit = (((rx_exp ^ match) & ~mask & lm) == 32'h0);
        occ = (occur == 8'd0) ? 1 : int'(occur);
        if (do_clr) begin m_cnt = 0; m_trig = 1'b0; end
        if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt >= occ) m_trig = 1'b1;
        end
        m_rx = rx_exp;
        e.rx = rx_exp; e.cnt = 8'(m_cnt); e.trig = m_trig;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            spi_bit(wire_msb ? v[n-1-i] : v[i],
                    (i == n-1) ? (do_clr ? 2 : (lat ? 1 : 0)) : 0);
        end
    endtask

    task automatic send_partial(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) spi_bit(v[n-1-i], 0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        check_val({tag, "_err_cnt"}, 64'(err_seen), 64'(err_exp));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; edg = 1'b1; lsb_first = 1'b0; len = 6'd16;
        mask = 32'h0; match = 32'h0; occur = 8'd1; clr_trig = 1'b0;
        SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b1;
        m_rx = 32'h0; m_cnt = 0; m_trig = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_trig", 64'(SPItrig), 64'd0);
        check_val("rst_done", 64'(frame_done), 64'd0);
        check_val("rst_err", 64'(frame_err), 64'd0);
        check_val("rst_rx", 64'(rx_data), 64'd0);
        check_val("rst_cnt", 64'(match_cnt), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 16-bit MSB-first match with latency check
        configure(6'd16, 1'b1, 1'b0, 32'h0, 32'hA5C3, 8'd1);
        ss_low();
        send_frame(32'hA5C3, 16, 1'b1, 1'b0, 1'b1);
        ss_high();
        check_idle("t1");

        // LSB-first decode, standalone clear, reversed order mismatch
        configure(6'd8, 1'b1, 1'b1, 32'h0, 32'h01, 8'd1);
        ss_low();
        send_frame(32'h01, 8, 1'b0, 1'b0, 1'b0);
        ss_high();
        clr_trig = 1'b1;
        @(negedge clk);
        clr_trig = 1'b0;
        m_cnt = 0; m_trig = 1'b0;
        @(negedge clk);
        check_val("clr_trig", 64'(SPItrig), 64'd0);
        check_val("clr_cnt", 64'(match_cnt), 64'd0);
        ss_low();
        send_frame(32'h01, 8, 1'b1, 1'b0, 1'b0);
        ss_high();
        check_val("t2_rx_rev", 64'(rx_data), 64'h80);
        check_idle("t2");

        // back-to-back masked frames, occurrence count 3
        configure(6'd12, 1'b1, 1'b0, 32'h00F, 32'hAB0, 8'd3);
        ss_low();
        send_frame(32'hAB1, 12, 1'b1, 1'b0, 1'b0);
        send_frame(32'hAB7, 12, 1'b1, 1'b0, 1'b0);
        send_frame(32'hABF, 12, 1'b1, 1'b0, 1'b0);
        ss_high();
        check_idle("t3");

        // truncated frame
        configure(6'd10, 1'b1, 1'b0, 32'h0, 32'h2A5, 8'd1);
        ss_low();
        send_frame(32'h2A5, 10, 1'b1, 1'b0, 1'b0);
        ss_high();
        ss_low();
        send_partial(32'h15, 6);
        ss_high();
        err_exp++;
        check_val("trunc_rx", 64'(rx_data), 64'h2A5);
        check_val("trunc_cnt", 64'(match_cnt), 64'd1);
        ss_low();
        send_frame(32'h13C, 10, 1'b1, 1'b0, 1'b0);
        ss_high();
        check_idle("t4");

        // clr_trig coincident with matching completion
        configure(6'd8, 1'b1, 1'b0, 32'h0, 32'h5A, 8'd2);
        ss_low();
        send_frame(32'h5A, 8, 1'b1, 1'b0, 1'b0);
        send_frame(32'h5A, 8, 1'b1, 1'b0, 1'b0);
        send_frame(32'h5A, 8, 1'b1, 1'b1, 1'b0);
        occur = 8'd1;
        send_frame(32'h5A, 8, 1'b1, 1'b0, 1'b0);
        send_frame(32'h5A, 8, 1'b1, 1'b1, 1'b0);
        ss_high();
        check_idle("t5");

        // len 0 as full width, falling-edge sampling, reset mid-frame
        configure(6'd0, 1'b0, 1'b0, 32'h0, 32'h0, 8'd1);
        ss_low();
        send_frame(32'hDEADBEEF, 32, 1'b1, 1'b0, 1'b0);
        send_partial(32'h2AA, 10);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_trig", 64'(SPItrig), 64'd0);
        check_val("mid_rst_rx", 64'(rx_data), 64'd0);
        check_val("mid_rst_cnt", 64'(match_cnt), 64'd0);
        check_val("mid_rst_done", 64'(frame_done), 64'd0);
        check_val("mid_rst_err", 64'(frame_err), 64'd0);
        SS_n = 1'b1; SCLK = ~edg;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_cnt = 0; m_trig = 1'b0; m_rx = 32'h0;
        repeat (4) @(negedge clk);
        ss_low();
        send_frame(32'h12345678, 32, 1'b1, 1'b0, 1'b0);
        ss_high();
        check_idle("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
